// File: rtl/vend_ctrl.sv
// Purpose : vending controller; accumulates coin credit, dispenses item A/B, pays change as unit pulses.
// Latency : every output is registered and responds one cycle after its inputs are sampled.
// Backpress: none; coins arriving while busy, on overflow or colliding with another coin/selection are
//            rejected with a coin_reject strobe.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   coin1, coin5        : one-cycle coin pulses (1 and 5 units)
//   sel                 : 00 none, 01 buy A, 10 buy B, 11 cancel
//   credit              : registered credit value
//   dispense_a/_b       : one-cycle item release strobes
//   change_pulse        : one strobe per unit of change returned
//   coin_reject         : inserted coin was returned unaccepted
//   busy                : high while dispensing or paying change
module vend_ctrl #(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 5,
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1,
    input  logic                coin5,
    input  logic [1:0]          sel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_a,
    output logic                dispense_b,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    // Credit arithmetic is carried one bit wider so credit + coin cannot wrap
    // before the MAX_CREDIT comparison.
    localparam logic [CREDIT_W:0]   PRICE_A_W = (CREDIT_W+1)'(PRICE_A);
    localparam logic [CREDIT_W:0]   PRICE_B_W = (CREDIT_W+1)'(PRICE_B);
    localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   COIN1_W   = (CREDIT_W+1)'(1);
    localparam logic [CREDIT_W:0]   COIN5_W   = (CREDIT_W+1)'(5);
    localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  dispense_a_q, dispense_a_d;
    logic                  dispense_b_q, dispense_b_d;
    logic                  change_pulse_q, change_pulse_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  busy_q, busy_d;

    logic                  coin_any;
    logic                  coin_both;
    logic                  buy;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     credit_ext;
    logic [CREDIT_W:0]     sum;
    logic [CREDIT_W:0]     price;

    always_comb begin
        coin_any   = coin1 | coin5;
        coin_both  = coin1 & coin5;
        buy        = (sel == 2'b01) || (sel == 2'b10);
        coin_val   = coin5 ? COIN5_W : COIN1_W;
        credit_ext = {1'b0, credit_q};
        sum        = credit_ext + coin_val;
        price      = (sel == 2'b01) ? PRICE_A_W : PRICE_B_W;

        state_d        = state_q;
        credit_d       = credit_q;
        dispense_a_d   = 1'b0;
        dispense_b_d   = 1'b0;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Two coins at once are not a valid coin; both go back.
                if (coin_both) begin
                    coin_reject_d = 1'b1;
                end else if (coin_any) begin
                    credit_d = coin_val[CREDIT_W-1:0];
                    state_d  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (coin_both) begin
                    coin_reject_d = 1'b1;
                end else if (sel == 2'b11) begin
                    coin_reject_d = coin_any;
                    if (credit_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        // The first change pulse is issued on the entry edge,
                        // so the pulse count equals the credit at cancel time.
                        state_d        = S_CHANGE;
                        credit_d       = credit_q - ONE;
                        change_pulse_d = 1'b1;
                    end
                end else if (buy && (credit_ext >= price)) begin
                    coin_reject_d = coin_any;
                    credit_d      = credit_q - price[CREDIT_W-1:0];
                    state_d       = S_DISPENSE;
                    // The strobe registers double as the latched item choice.
                    dispense_a_d  = (sel == 2'b01);
                    dispense_b_d  = (sel == 2'b10);
                end else if (coin_any) begin
                    // Insufficient-credit selections fall through to here.
                    if (sum <= MAX_W) begin
                        credit_d = sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            S_DISPENSE: begin
                coin_reject_d = coin_any;
                if (credit_q != '0) begin
                    state_d        = S_CHANGE;
                    credit_d       = credit_q - ONE;
                    change_pulse_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CHANGE: begin
                coin_reject_d = coin_any;
                if (credit_q != '0) begin
                    credit_d       = credit_q - ONE;
                    change_pulse_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            dispense_a_q   <= 1'b0;
            dispense_b_q   <= 1'b0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_a_q   <= dispense_a_d;
            dispense_b_q   <= dispense_b_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign dispense_a   = dispense_a_q;
    assign dispense_b   = dispense_b_q;
    assign change_pulse = change_pulse_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Purpose : scoreboard bench for vend_ctrl; directed test-plan sequences followed by random traffic.
// Latency : expected output for each driven cycle is checked one clock edge later.
// Backpress: none; the monitor checks every cycle that has a queued expectation.
module tb_vend_ctrl;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          coin1;
    logic          coin5;
    logic [1:0]    sel;
    logic [CW-1:0] credit;
    logic          dispense_a;
    logic          dispense_b;
    logic          change_pulse;
    logic          coin_reject;
    logic          busy;

    always #5 clk = ~clk;

    vend_ctrl #(
        .PRICE_A    (3),
        .PRICE_B    (5),
        .CREDIT_W   (CW),
        .MAX_CREDIT (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin1        (coin1),
        .coin5        (coin5),
        .sel          (sel),
        .credit       (credit),
        .dispense_a   (dispense_a),
        .dispense_b   (dispense_b),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    typedef struct packed {
        logic [CW-1:0] credit;
        logic          da;
        logic          db;
        logic          cp;
        logic          cr;
        logic          busy;
    } out_t;

    // Reference model: a purchase or cancel schedules the whole future output
    // sequence (dispense, then one entry per unit of change) into plan[].
    out_t exp_q[$];
    out_t plan[$];
    out_t last = '0;
    int   m_credit = 0;
    bit   collecting = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_cnt = 0;

    out_t mon_e;
    out_t mon_a;
    bit   r_c1, r_c5, r_rst;
    logic [1:0] r_sel;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic queue_change(input int n);
        out_t e;
        for (int k = n - 1; k >= 0; k--) begin
            e        = '0;
            e.credit = CW'(k);
            e.cp     = 1'b1;
            e.busy   = 1'b1;
            plan.push_back(e);
        end
    endtask

    task automatic model_step(input bit c1, input bit c5, input logic [1:0] s, input bit r);
        out_t nxt;
        bit   any;
        bit   both;
        int   val;
        int   price;
        nxt   = '0;
        any   = c1 | c5;
        both  = c1 & c5;
        val   = c5 ? 5 : 1;
        price = (s == 2'b01) ? 3 : 5;
        if (r) begin
            plan.delete();
            m_credit   = 0;
            collecting = 1'b0;
        end else if (last.busy) begin
            if (plan.size() > 0) nxt = plan.pop_front();
            nxt.cr   = any;
            m_credit = int'(nxt.credit);
        end else if (!collecting) begin
            if (both) nxt.cr = 1'b1;
            else if (any) begin
                m_credit   = val;
                collecting = 1'b1;
            end
            nxt.credit = CW'(m_credit);
        end else begin
            if (both) begin
                nxt.cr     = 1'b1;
                nxt.credit = CW'(m_credit);
            end else if (s == 2'b11) begin
                collecting = 1'b0;
                queue_change(m_credit);
                if (plan.size() > 0) nxt = plan.pop_front();
                nxt.cr   = any;
                m_credit = int'(nxt.credit);
            end else if (s != 2'b00 && m_credit >= price) begin
                m_credit  -= price;
                collecting = 1'b0;
                nxt.da     = (s == 2'b01);
                nxt.db     = (s == 2'b10);
                nxt.busy   = 1'b1;
                nxt.cr     = any;
                nxt.credit = CW'(m_credit);
                queue_change(m_credit);
            end else begin
                if (any) begin
                    if (m_credit + val <= 20) m_credit += val;
                    else nxt.cr = 1'b1;
                end
                nxt.credit = CW'(m_credit);
            end
        end
        last = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic drive(input bit c1, input bit c5, input logic [1:0] s, input bit r);
        @(negedge clk);
        coin1 = c1;
        coin5 = c5;
        sel   = s;
        rst   = r;
        model_step(c1, c5, s, r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expectation per clock and compares the full output set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {credit, dispense_a, dispense_b, change_pulse, coin_reject, busy};
                n_checks++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got credit=%0d da=%b db=%b cp=%b cr=%b busy=%b, expected credit=%0d da=%b db=%b cp=%b cr=%b busy=%b",
                             $time, mon_a.credit, mon_a.da, mon_a.db, mon_a.cp, mon_a.cr, mon_a.busy,
                             mon_e.credit, mon_e.da, mon_e.db, mon_e.cp, mon_e.cr, mon_e.busy);
                end
                check("strobe_exclusive",
                      int'((dispense_a & dispense_b) | ((dispense_a | dispense_b) & change_pulse)), 0);
                if (change_pulse === 1'b1) pulse_cnt++;
            end
        end
    end

    initial begin
        coin1 = 1'b0;
        coin5 = 1'b0;
        sel   = 2'b00;
        rst   = 1'b1;

        // 1: exact purchase of A
        drive(0, 0, 2'b00, 1);
        pulse_cnt = 0;
        drive(1, 0, 2'b00, 0);
        drive(1, 0, 2'b00, 0);
        drive(1, 0, 2'b00, 0);
        drive(0, 0, 2'b01, 0);
        idle(3);
        settle();
        check("exact_pulses", pulse_cnt, 0);

        // 2: purchase of B with 5 units of change
        drive(0, 0, 2'b00, 1);
        pulse_cnt = 0;
        drive(0, 1, 2'b00, 0);
        drive(0, 1, 2'b00, 0);
        drive(0, 0, 2'b10, 0);
        idle(8);
        settle();
        check("change_pulses", pulse_cnt, 5);

        // 3: insufficient credit, then cancel
        pulse_cnt = 0;
        drive(1, 0, 2'b00, 0);
        drive(1, 0, 2'b00, 0);
        drive(0, 0, 2'b10, 0);
        idle(1);
        drive(0, 0, 2'b11, 0);
        idle(4);
        settle();
        check("cancel_pulses", pulse_cnt, 2);

        // 4: overflow reject, simultaneous coins, drain 20 units
        pulse_cnt = 0;
        repeat (4) drive(0, 1, 2'b00, 0);
        drive(1, 0, 2'b00, 0);
        drive(1, 1, 2'b00, 0);
        drive(0, 0, 2'b11, 0);
        idle(22);
        settle();
        check("overflow_pulses", pulse_cnt, 20);

        // 5: coin during change, then sel/coin collision
        pulse_cnt = 0;
        drive(0, 1, 2'b00, 0);
        drive(0, 1, 2'b00, 0);
        drive(0, 0, 2'b11, 0);
        idle(2);
        drive(1, 0, 2'b00, 0);
        idle(10);
        settle();
        check("busy_coin_pulses", pulse_cnt, 10);
        repeat (3) drive(1, 0, 2'b00, 0);
        drive(1, 0, 2'b01, 0);
        idle(3);

        // 6: reset after 3 change pulses
        pulse_cnt = 0;
        drive(0, 1, 2'b00, 0);
        drive(0, 1, 2'b00, 0);
        drive(0, 0, 2'b11, 0);
        idle(2);
        drive(0, 0, 2'b00, 1);
        idle(5);
        settle();
        check("reset_mid_change_pulses", pulse_cnt, 3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r_c1  = ($urandom_range(0, 2) == 0);
            r_c5  = ($urandom_range(0, 3) == 0);
            r_sel = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_rst = ($urandom_range(0, 299) == 0);
            if (!collecting && !last.busy && r_c1 && r_c5) r_c5 = 1'b0;
            drive(r_c1, r_c5, r_sel, r_rst);
        end

        settle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
